hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Parametrised hazard, forwarding and kill controller for the Riscv151 pipeline family.
- Tracks every in-flight instruction between decode and writeback in a DEPTH-entry scoreboard shift register.
- From that state it generates per-source forwarding selects, load-use stalls, a multi-cycle kill window after redirects, and kill-qualified retire write enables.
- It replaces the fixed two-operand, three-stage bypass/kill logic inside the controller and sits beside the decoder, feeding the datapath bypass muxes.

Parameters:
- DEPTH, 2, scoreboard entries from the X stage (entry 1) to writeback (entry DEPTH); range 1..6.
- NUM_SRC, 2, source operands checked per decoded instruction; range 1..3.
- LOAD_LAT, 1, extra stages before a load result can be forwarded; range 0..DEPTH-1.
- KILL_CYCLES, 1, decode slots squashed per redirect, including the redirect cycle; range 1..4.
- AW, 5, register address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  decode holds a real instruction
- id_rd  in  AW  destination register
- id_we  in  1  instruction writes the register file
- id_is_load  in  1  instruction is a load
- id_rs  in  NUM_SRC*AW  source registers; source s occupies bits [s*AW +: AW]
- id_rs_used  in  NUM_SRC  source s is actually read
- redirect  in  1  taken branch or jump resolved this cycle
- stall  out  1  hold PC and decode; insert a bubble into X
- id_kill  out  1  squash the instruction in decode
- fwd_sel  out  NUM_SRC*FSW  decode-time select; 0 = register file, k = entry k result. FSW = $clog2(DEPTH+1)
- fwd_sel_x  out  NUM_SRC*FSW  fwd_sel registered into X
- retire_we  out  1  entry DEPTH is valid and writes
- retire_rd  out  AW  rd of entry DEPTH

Behaviour:
- Entry fields: {valid, we, is_load, rd}.
- Every cycle all entries shift: k -> k+1, and entry DEPTH is discarded.
- Entry 1 loads from decode as {id_valid & ~stall & ~id_kill, id_we, id_is_load, id_rd}. Otherwise entry 1 becomes a bubble (valid=0).
- Result availability:
  - A non-load result is forwardable from entry 1.
  - A load result is forwardable from entry 1+LOAD_LAT.
- Match rule for source s: id_rs_used[s], id_rs[s]!=0, and an entry k with valid & we & rd==id_rs[s].
- The youngest (smallest k) matching entry wins.
  - fwd_sel[s] = k when that entry's result is available.
  - No match: fwd_sel[s] = 0.
- stall = id_valid & ~id_kill & (some source matches an entry whose load result is not yet available).
  - During a stall, fwd_sel is don't-care but must not be X.
  - stall re-evaluates each cycle as the load advances.
- Kill counter (width $clog2(KILL_CYCLES+1)):
  - redirect loads the counter with KILL_CYCLES-1.
  - Otherwise the counter decrements while nonzero.
  - id_kill = redirect | (counter != 0).
  - A redirect while the counter is nonzero reloads it; windows do not accumulate.
- redirect and stall in the same cycle: id_kill wins, stall is forced to 0, and the decode instruction is dropped.
- fwd_sel_x:
  - Registers fwd_sel when stall=0 and id_kill=0.
  - Otherwise registers all zeros, since X receives a bubble.
- retire_we = entry DEPTH valid & we. retire_rd = entry DEPTH rd.
- Register x0 is never forwarded and never stalls.
- Reset:
  - Applied at the clk edge while reset=1: all entries are invalidated, counter=0, fwd_sel_x=0.
  - While reset=1, stall, id_kill and fwd_sel are forced to 0.
  - Reset mid-stall or mid-kill-window clears both on the next edge.
  - Outputs after reset: stall=0, id_kill=0, fwd_sel=0, fwd_sel_x=0, retire_we=0, retire_rd=0.

Test Plan:
Defaults DEPTH=2, NUM_SRC=2, LOAD_LAT=1, KILL_CYCLES=2.
- ALU back-to-back: add x5 issued, next cycle decode reads x5 on source 0 -> stall=0, fwd_sel[0]=1, then fwd_sel_x[0]=1 next cycle.
- Load-use: lw x7 issued, next decode reads x7 on source 1 -> stall=1 for exactly 1 cycle, then fwd_sel[1]=2 and retire_we=1 with retire_rd=7 on the following cycle.
- Youngest wins: addi x3 in entry 2, add x3 in entry 1, decode reads x3 on both sources -> fwd_sel=1 on both; x0 dependency -> 0, no stall.
- Redirect: redirect pulse -> id_kill=1 for 2 cycles; killed instructions never reach retire_we. Second redirect on cycle 2 -> id_kill stays high through cycle 3.
- Simultaneous: load-use stall condition and redirect in the same cycle -> stall=0, id_kill=1, bubble in entry 1.
- Reset mid-operation: reset during a stall with a valid load in entry 1 -> next cycle all outputs 0; sweep DEPTH=4, LOAD_LAT=2 -> a load-use hazard gives a 2-cycle stall, then fwd_sel=3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Scoreboard-based hazard, forwarding and kill controller for the Riscv151 pipeline.
// Tracks in-flight instructions from X to writeback and drives bypass selects, stalls and squashes.
module hazard_ctrl #(
    parameter int DEPTH       = 2,
    parameter int NUM_SRC     = 2,
    parameter int LOAD_LAT    = 1,
    parameter int KILL_CYCLES = 1,
    parameter int AW          = 5,
    localparam int FSW        = $clog2(DEPTH + 1),
    localparam int KCW        = $clog2(KILL_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [AW-1:0]          id_rd,
    input  logic                   id_we,
    input  logic                   id_is_load,
    input  logic [NUM_SRC*AW-1:0]  id_rs,
    input  logic [NUM_SRC-1:0]     id_rs_used,
    input  logic                   redirect,
    output logic                   stall,
    output logic                   id_kill,
    output logic [NUM_SRC*FSW-1:0] fwd_sel,
    output logic [NUM_SRC*FSW-1:0] fwd_sel_x,
    output logic                   retire_we,
    output logic [AW-1:0]          retire_rd
);

    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [DEPTH-1:0]              we_q, we_d;
    logic [DEPTH-1:0]              load_q, load_d;
    logic [DEPTH-1:0][AW-1:0]      rd_q, rd_d;
    logic [KCW-1:0]                kill_cnt_q, kill_cnt_d;
    logic [NUM_SRC*FSW-1:0]        fwd_sel_x_q, fwd_sel_x_d;

    logic [NUM_SRC*FSW-1:0]        fwd_raw;
    logic [NUM_SRC-1:0]            found;
    logic                          hazard;
    logic                          kill_raw;
    logic                          accept;

    // Youngest matching entry wins; a load too young to forward becomes a hazard instead.
    always_comb begin
        fwd_raw = '0;
        found   = '0;
        hazard  = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!found[s] && id_rs_used[s] && (id_rs[s*AW +: AW] != '0) &&
                    valid_q[k] && we_q[k] && (rd_q[k] == id_rs[s*AW +: AW])) begin
                    found[s] = 1'b1;
                    if (!load_q[k] || (k >= LOAD_LAT)) begin
                        fwd_raw[s*FSW +: FSW] = FSW'(k + 1);
                    end else begin
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        kill_raw = redirect | (kill_cnt_q != '0);
        id_kill  = ~reset & kill_raw;
        stall    = ~reset & id_valid & ~kill_raw & hazard;
        fwd_sel  = reset ? '0 : fwd_raw;
        accept   = id_valid & ~stall & ~id_kill;
    end

    always_comb begin
        valid_d = '0;
        we_d    = '0;
        load_d  = '0;
        rd_d    = '0;
        for (int k = DEPTH - 1; k > 0; k--) begin
            valid_d[k] = valid_q[k-1];
            we_d[k]    = we_q[k-1];
            load_d[k]  = load_q[k-1];
            rd_d[k]    = rd_q[k-1];
        end
        valid_d[0] = accept;
        we_d[0]    = id_we;
        load_d[0]  = id_is_load;
        rd_d[0]    = id_rd;

        // A redirect restarts the window rather than extending it.
        if (redirect) begin
            kill_cnt_d = KCW'(KILL_CYCLES - 1);
        end else if (kill_cnt_q != '0) begin
            kill_cnt_d = kill_cnt_q - KCW'(1);
        end else begin
            kill_cnt_d = kill_cnt_q;
        end

        fwd_sel_x_d = (stall | id_kill) ? '0 : fwd_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            we_q        <= '0;
            load_q      <= '0;
            rd_q        <= '0;
            kill_cnt_q  <= '0;
            fwd_sel_x_q <= '0;
        end else begin
            valid_q     <= valid_d;
            we_q        <= we_d;
            load_q      <= load_d;
            rd_q        <= rd_d;
            kill_cnt_q  <= kill_cnt_d;
            fwd_sel_x_q <= fwd_sel_x_d;
        end
    end

    assign fwd_sel_x = fwd_sel_x_q;
    assign retire_we = valid_q[DEPTH-1] & we_q[DEPTH-1];
    assign retire_rd = rd_q[DEPTH-1];

endmodule
